// File: rtl/adc_req_arbiter.sv
// Round-robin arbiter giving four requesters one-at-a-time access to a shared ADC sample stream.
// Optional macro ADC_ARB_AVG_EN: the response is the mean of two consecutive matching samples.
module adc_req_arbiter #(
  parameter int unsigned TIMEOUT = 2047
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [11:0] req_chan,
  input  logic        sample_valid,
  input  logic [2:0]  sample_chan,
  input  logic [11:0] sample_data,
  output logic [3:0]  grant,
  output logic [3:0]  resp_valid,
  output logic [11:0] resp_data,
  output logic        resp_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT_SKIP, WAIT_TAKE, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  grant_q, grant_d;
  logic [2:0]  chan_q, chan_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  last_q, last_d;
  logic [11:0] data_q, data_d;
  logic        err_q, err_d;

`ifdef ADC_ARB_AVG_EN
  logic        first_q, first_d;
  logic [11:0] s1_q, s1_d;
  logic [12:0] avg_sum;
  assign avg_sum = {1'b0, s1_q} + {1'b0, sample_data};
`endif

  logic [1:0]  win_idx;
  logic        win_found;
  logic        match;
  logic [16:0] cnt_inc;
  logic        tmo;

  // Search starts one past the previous winner; offset 4 wraps back to it so a sole requester repeats.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    for (int k = 1; k <= 4; k++) begin
      if (!win_found && req[last_q + 2'(k)]) begin
        win_found = 1'b1;
        win_idx   = last_q + 2'(k);
      end
    end
  end

  assign match   = sample_valid && (sample_chan == chan_q);
  assign cnt_inc = {1'b0, cnt_q} + 17'd1;
  assign tmo     = (cnt_inc == 17'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    chan_d  = chan_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    data_d  = data_q;
    err_d   = err_q;
`ifdef ADC_ARB_AVG_EN
    first_d = first_q;
    s1_d    = s1_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = 4'b0001 << win_idx;
          last_d  = win_idx;
          chan_d  = req_chan[3*win_idx +: 3];
          cnt_d   = 16'd0;
          data_d  = 12'd0;
          err_d   = 1'b0;
`ifdef ADC_ARB_AVG_EN
          first_d = 1'b0;
`endif
          state_d = WAIT_SKIP;
        end
      end
      WAIT_SKIP: begin
        cnt_d = cnt_inc[15:0];
        if (tmo) begin
          err_d   = 1'b1;
          data_d  = 12'd0;
          state_d = RESP;
        end else if (match) begin
          state_d = WAIT_TAKE;
        end
      end
      WAIT_TAKE: begin
        cnt_d = cnt_inc[15:0];
        // Timeout is checked first so it beats a strobe arriving in the same cycle.
        if (tmo) begin
          err_d   = 1'b1;
          data_d  = 12'd0;
          state_d = RESP;
        end else if (match) begin
`ifdef ADC_ARB_AVG_EN
          if (!first_q) begin
            s1_d    = sample_data;
            first_d = 1'b1;
          end else begin
            data_d  = avg_sum[12:1];
            state_d = RESP;
          end
`else
          data_d  = sample_data;
          state_d = RESP;
`endif
        end
      end
      RESP: begin
        grant_d = 4'b0000;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
      chan_q  <= 3'd0;
      cnt_q   <= 16'd0;
      last_q  <= 2'd3;
      data_q  <= 12'd0;
      err_q   <= 1'b0;
`ifdef ADC_ARB_AVG_EN
      first_q <= 1'b0;
      s1_q    <= 12'd0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      chan_q  <= chan_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      data_q  <= data_d;
      err_q   <= err_d;
`ifdef ADC_ARB_AVG_EN
      first_q <= first_d;
      s1_q    <= s1_d;
`endif
    end
  end

  assign grant      = grant_q;
  assign resp_valid = (state_q == RESP) ? grant_q : 4'b0000;
  assign resp_data  = (state_q == RESP) ? data_q : 12'd0;
  assign resp_err   = (state_q == RESP) ? err_q : 1'b0;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_adc_req_arbiter.sv
// Scoreboard bench for adc_req_arbiter: directed transactions push expected responses,
// a negedge monitor pops and compares each response pulse.
module tb_adc_req_arbiter;

  localparam int unsigned TMO = 20;
`ifdef ADC_ARB_AVG_EN
  localparam int AVG_EXTRA = 1;
`else
  localparam int AVG_EXTRA = 0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = 4'd0;
  logic [11:0] req_chan = 12'd0;
  logic        sample_valid = 1'b0;
  logic [2:0]  sample_chan = 3'd0;
  logic [11:0] sample_data = 12'd0;
  logic [3:0]  grant;
  logic [3:0]  resp_valid;
  logic [11:0] resp_data;
  logic        resp_err;
  logic        busy;

  typedef struct packed {
    logic [3:0]  g;
    logic [11:0] d;
    logic        e;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  adc_req_arbiter #(.TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .req(req), .req_chan(req_chan),
    .sample_valid(sample_valid), .sample_chan(sample_chan), .sample_data(sample_data),
    .grant(grant), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .busy(busy)
  );

  always #10 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [3:0] g, input logic [11:0] d, input logic e);
    exp_t x;
    x.g = g; x.d = d; x.e = e;
    exp_q.push_back(x);
  endtask

  task automatic strobe(input logic [2:0] ch, input logic [11:0] d);
    sample_valid = 1'b1;
    sample_chan  = ch;
    sample_data  = d;
    step();
    sample_valid = 1'b0;
  endtask

  // Capture strobe(s): same data twice in averaging mode so the mean equals d.
  task automatic take(input logic [2:0] ch, input logic [11:0] d);
`ifdef ADC_ARB_AVG_EN
    strobe(ch, d);
`endif
    strobe(ch, d);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = 4'd0;
    sample_valid = 1'b0;
    step();
    step();
    mon_en = 1'b1;
    check("rst_grant", grant, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_err", resp_err, 0);
    reset = 1'b0;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    while (grant == 4'd0 && n < 40) begin
      step();
      n++;
    end
    check("wait_grant", (grant != 4'd0), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 80) begin
      step();
      n++;
    end
    check("wait_idle", busy, 0);
  endtask

  // Monitor: every response pulse must match the oldest expected entry.
  always @(negedge clock) begin
    if (mon_en) begin
      if (resp_valid != 4'd0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp actual=%b required=none", resp_valid);
        end else begin
          exp_t x;
          x = exp_q.pop_front();
          check("resp_valid", resp_valid, x.g);
          check("resp_data", resp_data, x.d);
          check("resp_err", resp_err, x.e);
          $display("resp valid=%b data=%h err=%b (expected %b %h %b)",
                   resp_valid, resp_data, resp_err, x.g, x.d, x.e);
        end
      end else begin
        check("idle_data_zero", {resp_err, resp_data}, 0);
      end
    end
  end

  initial begin
    int n;
    logic [3:0] rr_exp [5];
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

    // Single requester, skip then take, with a foreign-channel strobe ignored.
    do_reset();
    req_chan = 12'd5;
    req = 4'b0001;
    step();
    check("t1_grant", grant, 4'b0001);
    req = 4'b0000;
    push(4'b0001, 12'h222, 1'b0);
    strobe(3'd4, 12'h333);
    strobe(3'd5, 12'h111);
    take(3'd5, 12'h222);
    wait_idle();

    // All four requesting: round-robin order, sole-bit response pulses.
    do_reset();
    req_chan = {3'd4, 3'd3, 3'd2, 3'd1};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [2:0] ch;
      wait_grant(n);
      check("rr_grant", grant, rr_exp[k]);
      if (k == 4) req = 4'b0000;
      ch = (rr_exp[k] == 4'b0001) ? 3'd1 : (rr_exp[k] == 4'b0010) ? 3'd2 :
           (rr_exp[k] == 4'b0100) ? 3'd3 : 3'd4;
      push(rr_exp[k], 12'h100 + 12'(k), 1'b0);
      strobe(ch, 12'hEEE);
      take(ch, 12'h100 + 12'(k));
      wait_idle();
    end

    // Pure timeout: response arrives on the 21st cycle after grant.
    do_reset();
    req_chan = 12'(6 << 3);
    req = 4'b0010;
    step();
    check("tmo_grant", grant, 4'b0010);
    req = 4'b0000;
    push(4'b0010, 12'h000, 1'b1);
    n = 1;
    strobe(3'd2, 12'h555);
    n++;
    while (resp_valid == 4'd0 && n < 100) begin
      step();
      n++;
    end
    check("tmo_latency", n, TMO + 1);
    wait_idle();

    // Capture on the last wait cycle before timeout succeeds.
    do_reset();
    req_chan = 12'(6 << 3);
    req = 4'b0010;
    step();
    req = 4'b0000;
    strobe(3'd6, 12'h7AA);
    repeat (17 - AVG_EXTRA) step();
    push(4'b0010, 12'h5C3, 1'b0);
    take(3'd6, 12'h5C3);
    wait_idle();

    // Matching strobe in the timeout cycle loses to the timeout.
    do_reset();
    req_chan = 12'(6 << 3);
    req = 4'b0010;
    step();
    req = 4'b0000;
    strobe(3'd6, 12'h7AA);
    repeat (18) step();
    push(4'b0010, 12'h000, 1'b1);
    strobe(3'd6, 12'h3C3);
    wait_idle();

    // Grant-cycle strobe ignored; req_chan change after grant has no effect.
    do_reset();
    req_chan = 12'(3 << 6);
    req = 4'b0100;
    sample_valid = 1'b1;
    sample_chan = 3'd3;
    sample_data = 12'h0FF;
    step();
    sample_valid = 1'b0;
    check("gc_grant", grant, 4'b0100);
    req = 4'b0000;
    req_chan = 12'(1 << 6);
    push(4'b0100, 12'h0B0, 1'b0);
    strobe(3'd3, 12'h0A0);
    take(3'd3, 12'h0B0);
    wait_idle();

    // Reset in WAIT_TAKE aborts silently; requester 0 then wins first.
    do_reset();
    req_chan = {3'd7, 3'd0, 3'd0, 3'd2};
    req = 4'b0001;
    step();
    req = 4'b0000;
    strobe(3'd2, 12'h123);
    check("abort_busy_before", busy, 1);
    reset = 1'b1;
    sample_valid = 1'b1;
    sample_chan = 3'd2;
    sample_data = 12'h456;
    step();
    sample_valid = 1'b0;
    check("abort_grant", grant, 0);
    check("abort_resp_valid", resp_valid, 0);
    check("abort_busy", busy, 0);
    reset = 1'b0;
    req = 4'b1001;
    wait_grant(n);
    check("abort_next_grant", grant, 4'b0001);
    req = 4'b0000;
    push(4'b0001, 12'h789, 1'b0);
    strobe(3'd2, 12'h000);
    take(3'd2, 12'h789);
    wait_idle();

`ifdef ADC_ARB_AVG_EN
    // Averaging: (0xFFF + 0xFFE) >> 1 in 13 bits.
    do_reset();
    req_chan = 12'd2;
    req = 4'b0001;
    step();
    req = 4'b0000;
    push(4'b0001, 12'hFFE, 1'b0);
    strobe(3'd2, 12'h111);
    strobe(3'd2, 12'hFFF);
    strobe(3'd2, 12'hFFE);
    wait_idle();
`endif

    repeat (3) step();
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
